// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire sequencer.
// DHT11_CHECKSUM_EN enables checksum rejection of received frames.
package dht11_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_RELEASE,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_DONE,
    ST_ERR
  } dht11_state_e;

  localparam logic [1:0] DHT11_ERR_NONE    = 2'd0;
  localparam logic [1:0] DHT11_ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] DHT11_ERR_CSUM    = 2'd2;

  localparam int DHT11_FRAME_BITS = 40;

  function automatic logic dht11_csum_ok(
    input logic [39:0] f
  );
    logic [7:0] s;
    s = f[39:32] + f[31:24]
      + f[23:16] + f[15:8];
    return s == f[7:0];
  endfunction

endpackage

// File: rtl/dht11_bus_ctrl_if.sv
// Register-side handshake bundle of the DHT11 sequencer.
// master = register slave, slave = sequencer.
interface dht11_bus_ctrl_if;

  logic       start;
  logic       busy;
  logic       data_valid;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] tmp_int;
  logic [7:0] tmp_dec;
  logic [1:0] err;

  modport master (
    output start,
    input  busy, data_valid,
    input  hum_int, hum_dec,
    input  tmp_int, tmp_dec,
    input  err
  );

  modport slave (
    input  start,
    output busy, data_valid,
    output hum_int, hum_dec,
    output tmp_int, tmp_dec,
    output err
  );

endinterface

// File: rtl/dht11_us_tick.sv
// Microsecond tick divider; clr restarts the period so
// phase widths are measured from the state change.
module dht11_us_tick #(
  parameter int CLK_FREQ_MHZ = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W =
    ($clog2(CLK_FREQ_MHZ) > 0) ?
    $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [W-1:0] LAST =
    W'(CLK_FREQ_MHZ - 1);

  logic [W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q + 1'b1;
    if (clr || div_q == LAST)
      div_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  assign tick = (div_q == LAST);

endmodule

// File: rtl/dht11_bus_ctrl.sv
// DHT11 single-wire read sequencer: start pulse, response, 40 bits.
// Define DHT11_CHECKSUM_EN to reject frames with a bad checksum.
module dht11_bus_ctrl
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_MHZ  = 100,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 40
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic dht_in,
  output logic dht_oe,
  dht11_bus_ctrl_if.slave bus
);

`ifdef DHT11_CHECKSUM_EN
  localparam int SHIFT_W = DHT11_FRAME_BITS;
`else
  localparam int SHIFT_W = DHT11_FRAME_BITS - 8;
`endif
  localparam int LSB = SHIFT_W - 32;

  localparam logic [15:0] START_LIM =
    16'(START_LOW_US);
  localparam logic [15:0] TMO_LIM =
    16'(TIMEOUT_US);
  localparam logic [15:0] THR =
    16'(BIT_THRESH_US);
  localparam logic [5:0] LAST_BIT =
    6'(DHT11_FRAME_BITS - 1);
  localparam logic [5:0] KEEP_BITS =
    6'(SHIFT_W);

  dht11_state_e state_q, state_d;

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic oe_q, oe_d;
  logic busy_q, busy_d;
  logic dv_q, dv_d;
  logic [1:0] err_q, err_d;
  logic [15:0] us_cnt_q, us_cnt_d;
  logic [5:0] bit_idx_q, bit_idx_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] hd_q, hd_d;
  logic [7:0] ti_q, ti_d;
  logic [7:0] td_q, td_d;

  logic tick;
  logic chg;
  logic fall;
  logic rise;
  logic timed;
  logic bit_val;

  dht11_us_tick #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
  ) u_tick (
    .clk  (ACLK),
    .rst_n(ARESETN),
    .clr  (chg),
    .tick (tick)
  );

  assign fall = prev_q & ~sync2_q;
  assign rise = ~prev_q & sync2_q;
  assign bit_val = (us_cnt_q > THR);
  assign chg = (state_d != state_q);

  always_comb begin
    timed = 1'b0;
    unique case (state_q)
      ST_RELEASE, ST_RESP_LOW,
      ST_RESP_HIGH, ST_BIT_LOW,
      ST_BIT_HIGH:
        timed = (us_cnt_q == TMO_LIM);
      default: timed = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sync1_d   = dht_in;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    dv_d      = 1'b0;
    err_d     = err_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    hi_d      = hi_q;
    hd_d      = hd_q;
    ti_d      = ti_q;
    td_d      = td_q;
    if (timed) begin
      state_d = ST_ERR;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.start) begin
          state_d = ST_START_LOW;
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          err_d   = DHT11_ERR_NONE;
        end
        ST_START_LOW:
          if (us_cnt_q == START_LIM) begin
            state_d = ST_RELEASE;
            oe_d    = 1'b0;
          end
        ST_RELEASE:
          if (fall) state_d = ST_RESP_LOW;
        ST_RESP_LOW:
          if (rise) state_d = ST_RESP_HIGH;
        ST_RESP_HIGH: if (fall) begin
          state_d   = ST_BIT_LOW;
          bit_idx_d = '0;
        end
        ST_BIT_LOW:
          if (rise) state_d = ST_BIT_HIGH;
        ST_BIT_HIGH: if (fall) begin
          // Bits past SHIFT_W carry only the checksum.
          if (bit_idx_q < KEEP_BITS)
            shift_d = {shift_q[SHIFT_W-2:0],
                       bit_val};
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_DONE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = ST_BIT_LOW;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
`ifdef DHT11_CHECKSUM_EN
          if (dht11_csum_ok(shift_q)) begin
            dv_d = 1'b1;
            hi_d = shift_q[LSB+24 +: 8];
            hd_d = shift_q[LSB+16 +: 8];
            ti_d = shift_q[LSB+8 +: 8];
            td_d = shift_q[LSB +: 8];
          end else begin
            err_d = DHT11_ERR_CSUM;
          end
`else
          dv_d = 1'b1;
          hi_d = shift_q[LSB+24 +: 8];
          hd_d = shift_q[LSB+16 +: 8];
          ti_d = shift_q[LSB+8 +: 8];
          td_d = shift_q[LSB +: 8];
`endif
        end
        ST_ERR: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = DHT11_ERR_TIMEOUT;
        end
        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
    us_cnt_d = us_cnt_q + {15'd0, tick};
    if (chg) us_cnt_d = '0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      err_q     <= DHT11_ERR_NONE;
      us_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      hi_q      <= '0;
      hd_q      <= '0;
      ti_q      <= '0;
      td_q      <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
      us_cnt_q  <= us_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      hi_q      <= hi_d;
      hd_q      <= hd_d;
      ti_q      <= ti_d;
      td_q      <= td_d;
    end
  end

  assign dht_oe         = oe_q;
  assign bus.busy       = busy_q;
  assign bus.data_valid = dv_q;
  assign bus.err        = err_q;
  assign bus.hum_int    = hi_q;
  assign bus.hum_dec    = hd_q;
  assign bus.tmp_int    = ti_q;
  assign bus.tmp_dec    = td_q;

endmodule
